instr_fetch_unit: RTL and testbench

//  Upstream stage of Control_Unit. Owns PC and IR, fetches one 16-bit instruction word per

---
 rtl/instr_fetch_unit.sv | 182 ++++++++++++++++++
 tb/tb_instr_fetch_unit.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch_unit.sv
// ============================================================================
// instr_fetch_unit
// ----------------------------------------------------------------------------
// Front-end stage for Control_Unit. Owns the program counter (PC) and the
// instruction register (IR). For each instruction it:
//   1. spends one idle cycle with no memory request,
//   2. fetches one 16-bit word from word-addressed memory over a req/ack port,
//   3. presents the decoded fields with a one-cycle instr_valid pulse,
//   4. waits for the datapath to signal instr_done, then selects the next PC.
// After the first instruction, the idle cycle is skipped: retirement goes
// straight back to fetch. A new instruction therefore costs at least two
// cycles (fetch + issue).
//
// Optional feature macro: FETCH_COUNT_EN
//   defined   : instr_count counts accepted instr_done events (wraps at 2^32)
//   undefined : no counter logic, instr_count is tied to zero
//
// Parameters
//   AW        PC / memory address width in words (must be greater than 8)
//   RESET_PC  PC value loaded on Reset
//
// Ports
//   CLK          in   1    clock; all state changes on the rising edge
//   Reset        in   1    synchronous, active-high; wins over every other input
//   mem_req      out  1    read request, high only while fetching
//   mem_addr     out  AW   PC while mem_req is high, otherwise zero
//   mem_ack      in   1    read data valid; only looked at while fetching
//   mem_rdata    in   16   instruction word
//   Opcode       out  4    IR[15:12]
//   Rd           out  4    IR[11:8]
//   Rs           out  4    IR[7:4]
//   Imm8         out  8    IR[7:0]; branch offset / immediate
//   instr_valid  out  1    one-cycle pulse when a new IR is presented
//   instr_done   in   1    datapath finished the current instruction
//   PCSrc        in   2    next-PC select, sampled with instr_done
//   Zero         in   1    ALU zero flag, sampled with instr_done
//   jump_addr    in   AW   absolute target for PCSrc = 2'b10
//   pc_out       out  AW   current PC (link value for jal)
//   instr_count  out  32   retired-instruction count (see FETCH_COUNT_EN)
// ============================================================================
module instr_fetch_unit #(
    parameter int unsigned          AW       = 16,
    parameter logic [AW-1:0]        RESET_PC = '0
) (
    input  logic            CLK,
    input  logic            Reset,
    output logic            mem_req,
    output logic [AW-1:0]   mem_addr,
    input  logic            mem_ack,
    input  logic [15:0]     mem_rdata,
    output logic [3:0]      Opcode,
    output logic [3:0]      Rd,
    output logic [3:0]      Rs,
    output logic [7:0]      Imm8,
    output logic            instr_valid,
    input  logic            instr_done,
    input  logic [1:0]      PCSrc,
    input  logic            Zero,
    input  logic [AW-1:0]   jump_addr,
    output logic [AW-1:0]   pc_out,
    output logic [31:0]     instr_count
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_ISSUE = 2'd2,
        S_EXEC  = 2'd3
    } state_t;

    localparam logic [AW-1:0] PC_ONE = AW'(1);

    state_t           r_state;
    logic [AW-1:0]    r_pc;
    logic [15:0]      r_ir;
    logic             r_mem_req;
    logic             r_instr_valid;

    logic             w_accept;
    logic [AW-1:0]    w_pc_inc;
    logic [AW-1:0]    w_imm_sext;
    logic [AW-1:0]    w_next_pc;

    // instr_done only means something while an instruction is in flight.
    assign w_accept   = instr_done && ((r_state == S_ISSUE) || (r_state == S_EXEC));

    // All PC arithmetic wraps naturally at AW bits.
    assign w_pc_inc   = r_pc + PC_ONE;
    assign w_imm_sext = {{(AW-8){r_ir[7]}}, r_ir[7:0]};

    always_comb begin
        w_next_pc = w_pc_inc;
        case (PCSrc)
            2'b01: begin
                if (Zero) begin
                    w_next_pc = w_pc_inc + w_imm_sext;
                end
            end
            2'b10:   w_next_pc = jump_addr;
            default: w_next_pc = w_pc_inc;   // 2'b00 and reserved 2'b11
        endcase
    end

    // Sequencer. mem_req and instr_valid are registered alongside the state
    // so they are clean decodes of it: mem_req <=> FETCH, instr_valid <=> ISSUE.
    always_ff @(posedge CLK) begin
        if (Reset) begin
            r_state       <= S_IDLE;
            r_pc          <= RESET_PC;
            r_ir          <= '0;
            r_mem_req     <= 1'b0;
            r_instr_valid <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    // One request-free cycle so a late ack from an aborted
                    // fetch cannot be mistaken for the new one.
                    r_state       <= S_FETCH;
                    r_mem_req     <= 1'b1;
                    r_instr_valid <= 1'b0;
                end
                S_FETCH: begin
                    if (mem_ack) begin
                        r_ir          <= mem_rdata;
                        r_state       <= S_ISSUE;
                        r_mem_req     <= 1'b0;
                        r_instr_valid <= 1'b1;
                    end
                end
                S_ISSUE: begin
                    r_instr_valid <= 1'b0;
                    if (w_accept) begin
                        r_pc      <= w_next_pc;
                        r_state   <= S_FETCH;
                        r_mem_req <= 1'b1;
                    end else begin
                        r_state   <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    if (w_accept) begin
                        r_pc      <= w_next_pc;
                        r_state   <= S_FETCH;
                        r_mem_req <= 1'b1;
                    end
                end
                default: begin
                    r_state       <= S_IDLE;
                    r_mem_req     <= 1'b0;
                    r_instr_valid <= 1'b0;
                end
            endcase
        end
    end

`ifdef FETCH_COUNT_EN
    logic [31:0] r_instr_count;

    always_ff @(posedge CLK) begin
        if (Reset) begin
            r_instr_count <= '0;
        end else if (w_accept) begin
            r_instr_count <= r_instr_count + 32'd1;
        end
    end

    assign instr_count = r_instr_count;
`else
    assign instr_count = '0;
`endif

    assign mem_req     = r_mem_req;
    assign mem_addr    = r_mem_req ? r_pc : '0;
    assign instr_valid = r_instr_valid;
    assign pc_out      = r_pc;

    assign Opcode      = r_ir[15:12];
    assign Rd          = r_ir[11:8];
    assign Rs          = r_ir[7:4];
    assign Imm8        = r_ir[7:0];

endmodule

// File: tb/tb_instr_fetch_unit.sv
// ============================================================================
// tb_instr_fetch_unit
// ----------------------------------------------------------------------------
// Transaction-level bench for instr_fetch_unit. Each instruction is one
// transaction: the ack latency, the instruction word, the datapath latency and
// the next-PC controls. The expected PC comes from plain integer arithmetic.
// Inputs are driven and outputs sampled on the falling edge.
// ============================================================================
module tb_instr_fetch_unit;

    localparam logic [15:0] RST_PC = 16'h0000;

    logic        clk;
    logic        reset;
    logic        mem_req;
    logic [15:0] mem_addr;
    logic        mem_ack;
    logic [15:0] mem_rdata;
    logic [3:0]  opcode;
    logic [3:0]  rd;
    logic [3:0]  rs;
    logic [7:0]  imm8;
    logic        instr_valid;
    logic        instr_done;
    logic [1:0]  pcsrc;
    logic        zero;
    logic [15:0] jump_addr;
    logic [15:0] pc_out;
    logic [31:0] instr_count;

    int          n_cmp;
    int          n_err;

    // Reference state
    logic [15:0] exp_pc;
    logic [15:0] exp_ir;
    int          retired;

    instr_fetch_unit #(
        .AW       (16),
        .RESET_PC (RST_PC)
    ) dut (
        .CLK         (clk),
        .Reset       (reset),
        .mem_req     (mem_req),
        .mem_addr    (mem_addr),
        .mem_ack     (mem_ack),
        .mem_rdata   (mem_rdata),
        .Opcode      (opcode),
        .Rd          (rd),
        .Rs          (rs),
        .Imm8        (imm8),
        .instr_valid (instr_valid),
        .instr_done  (instr_done),
        .PCSrc       (pcsrc),
        .Zero        (zero),
        .jump_addr   (jump_addr),
        .pc_out      (pc_out),
        .instr_count (instr_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%h expected 0x%h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] ref_next(input logic [15:0] pc, input logic [1:0] src,
                                             input logic z, input logic [7:0] imm,
                                             input logic [15:0] ja);
        int off;
        int t;
        off = (imm >= 8'd128) ? int'(imm) - 256 : int'(imm);
        if (src == 2'b10) return ja;
        t = int'(pc) + 1;
        if (src == 2'b01 && z) t = t + off;
        return 16'(t & 32'hFFFF);
    endfunction

    function automatic logic [31:0] exp_count();
`ifdef FETCH_COUNT_EN
        return 32'(retired);
`else
        return 32'd0;
`endif
    endfunction

    // Reset for n cycles with a stale ack asserted throughout; it must be ignored.
    task automatic do_reset(input int n);
        reset     = 1'b1;
        mem_ack   = 1'b1;
        mem_rdata = 16'hDEAD;
        instr_done = 1'b1;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            check("rst_req",   32'(mem_req), 0);
            check("rst_valid", 32'(instr_valid), 0);
            check("rst_addr",  32'(mem_addr), 0);
            check("rst_pc",    32'(pc_out), 32'(RST_PC));
            check("rst_ir",    {16'h0, opcode, rd, imm8}, 0);
            check("rst_cnt",   instr_count, 0);
        end
        reset      = 1'b0;
        instr_done = 1'b0;
        mem_rdata  = 16'h2A35;
        exp_pc     = RST_PC;
        exp_ir     = 16'h0;
        retired    = 0;
        // Idle cycle follows; next falling edge sees the fetch.
        @(negedge clk);
    endtask

    // Entry and exit: at a falling edge with the DUT requesting a fetch.
    task automatic do_instr(input int ack_dly, input logic [15:0] word, input int done_dly,
                            input logic [1:0] src, input logic z, input logic [15:0] ja);
        for (int d = 0; d <= ack_dly; d++) begin
            check("fetch_req",   32'(mem_req), 1);
            check("fetch_addr",  32'(mem_addr), 32'(exp_pc));
            check("fetch_valid", 32'(instr_valid), 0);
            check("fetch_ir",    {16'h0, opcode, rd, imm8}, 32'(exp_ir));
            instr_done = 1'($urandom);          // ignored while fetching
            pcsrc      = 2'($urandom);
            zero       = 1'($urandom);
            jump_addr  = 16'($urandom);
            mem_ack    = (d == ack_dly);
            mem_rdata  = mem_ack ? word : 16'($urandom);
            @(negedge clk);
        end
        exp_ir    = word;
        mem_ack   = 1'($urandom);               // ignored outside fetch
        mem_rdata = 16'($urandom);
        check("issue_valid", 32'(instr_valid), 1);
        check("issue_req",   32'(mem_req), 0);
        check("issue_addr",  32'(mem_addr), 0);
        check("issue_op",    32'(opcode), 32'(word[15:12]));
        check("issue_rd",    32'(rd), 32'(word[11:8]));
        check("issue_rs",    32'(rs), 32'(word[7:4]));
        check("issue_imm",   32'(imm8), 32'(word[7:0]));
        check("issue_pc",    32'(pc_out), 32'(exp_pc));
        check("issue_cnt",   instr_count, exp_count());
        for (int k = 0; k <= done_dly; k++) begin
            instr_done = (k == done_dly);
            pcsrc      = (k == done_dly) ? src : 2'($urandom);
            zero       = (k == done_dly) ? z   : 1'($urandom);
            jump_addr  = (k == done_dly) ? ja  : 16'($urandom);
            @(negedge clk);
            if (k < done_dly) begin
                check("exec_valid", 32'(instr_valid), 0);
                check("exec_req",   32'(mem_req), 0);
                check("exec_ir",    {16'h0, opcode, rd, imm8}, 32'(word));
            end
        end
        instr_done = 1'b0;
        mem_ack    = 1'b0;
        exp_pc     = ref_next(exp_pc, src, z, word[7:0], ja);
        retired++;
    endtask

    // Abort a fetch with reset while the memory is acking.
    task automatic abort_fetch(input int wait_cyc);
        for (int i = 0; i < wait_cyc; i++) begin
            mem_ack = 1'b0;
            @(negedge clk);
        end
        reset     = 1'b1;
        mem_ack   = 1'b1;
        mem_rdata = 16'hBEEF;
        @(negedge clk);
        check("abort_req", 32'(mem_req), 0);
        check("abort_ir",  {16'h0, opcode, rd, imm8}, 0);
        check("abort_pc",  32'(pc_out), 32'(RST_PC));
        check("abort_cnt", instr_count, 0);
        reset     = 1'b0;                       // ack stays high through idle
        mem_rdata = 16'hCAFE;
        @(negedge clk);
        check("abort_idle_ir", {16'h0, opcode, rd, imm8}, 0);
        mem_ack = 1'b0;
        exp_pc  = RST_PC;
        exp_ir  = 16'h0;
        retired = 0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        n_cmp      = 0;
        n_err      = 0;
        reset      = 1'b1;
        mem_ack    = 1'b0;
        mem_rdata  = 16'h0;
        instr_done = 1'b0;
        pcsrc      = 2'b00;
        zero       = 1'b0;
        jump_addr  = 16'h0;
        exp_pc     = RST_PC;
        exp_ir     = 16'h0;
        retired    = 0;

        do_reset(3);
        // zero-wait first fetch
        do_instr(0, 16'h2A35, 0, 2'b00, 1'b0, 16'h0);
        // delayed ack, delayed done
        do_instr(3, 16'h1234, 1, 2'b00, 1'b0, 16'h0);
        // branch backwards / not taken from 0x0010
        do_instr(0, 16'h7000, 0, 2'b10, 1'b0, 16'h0010);
        do_instr(1, 16'h51FE, 2, 2'b01, 1'b1, 16'h0);
        do_instr(0, 16'h7000, 0, 2'b10, 1'b0, 16'h0010);
        do_instr(0, 16'h51FE, 0, 2'b01, 1'b0, 16'h0);
        // wrap and jump; reserved select behaves as increment
        do_instr(0, 16'h7000, 0, 2'b10, 1'b0, 16'hFFFF);
        do_instr(0, 16'h0000, 0, 2'b00, 1'b0, 16'h0);
        do_instr(0, 16'h0000, 1, 2'b11, 1'b1, 16'h5555);
        do_instr(0, 16'h7000, 0, 2'b10, 1'b0, 16'h1234);
        do_instr(2, 16'h3C80, 0, 2'b01, 1'b1, 16'h0);
        // reset during fetch with pending ack
        abort_fetch(1);
        do_instr(0, 16'hABCD, 0, 2'b00, 1'b0, 16'h0);

        // retirement counter
        do_reset(1);
        for (int i = 0; i < 5; i++) begin
            do_instr(int'($urandom_range(0, 2)), 16'($urandom), int'($urandom_range(0, 2)),
                     2'b00, 1'b0, 16'h0);
        end
`ifdef FETCH_COUNT_EN
        check("count5", instr_count, 32'd5);
`else
        check("count5", instr_count, 32'd0);
`endif

        // randomized traffic
        for (int i = 0; i < 80; i++) begin
            if ($urandom_range(0, 14) == 0) begin
                abort_fetch(int'($urandom_range(0, 2)));
            end else begin
                do_instr(int'($urandom_range(0, 3)), 16'($urandom), int'($urandom_range(0, 3)),
                         2'($urandom), 1'($urandom), 16'($urandom));
            end
        end
        check("final_addr", 32'(mem_addr), 32'(exp_pc));
        check("final_cnt",  instr_count, exp_count());

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
